branch_resolve_unit: RTL

- Sits downstream of the execute-stage ALU and consumes its N/Z/C/V flags. The ALU computes rs1 - rs2 with ALUcontrol = 001.
- Resolves RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and unconditional jumps (JAL/JALR).
- Issues a PC redirect to fetch over a valid/ready handshake, then holds a pipeline flush for a programmable number of cycles.
- Static predict-not-taken: only taken branches and jumps redirect.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/branch_cond_eval.sv | 29 ++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V branch encodings and branch unit state encoding
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BRU_IDLE  = 2'd0,
        BRU_HOLD  = 2'd1,
        BRU_FLUSH = 2'd2
    } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - branch condition from funct3 and ALU flags of rs1 - rs2
module branch_cond_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    output logic       taken,
    output logic       illegal
);

    // C is "no borrow", so unsigned less-than is ~C.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = Z;
            F3_BNE:  taken = ~Z;
            F3_BLT:  taken = N ^ V;
            F3_BGE:  taken = ~(N ^ V);
            F3_BLTU: taken = ~C;
            F3_BGEU: taken = C;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branches/jumps, issues PC redirect and timed flush
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_target,
    output logic             flush,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FCW'(FLUSH_CYCLES - 1) : '0;

    bru_state_e       state_q, state_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic             cond_taken;
    logic             cond_illegal;
    logic             accept;
    logic             take;
    logic [XLEN-1:0]  pc_sum;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target_w;

    branch_cond_eval u_cond (
        .funct3  (ex_funct3),
        .N       (N),
        .Z       (Z),
        .C       (C),
        .V       (V),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign ex_ready = (state_q == BRU_IDLE);
    assign accept   = ex_valid & ex_ready & (ex_is_branch | ex_is_jump);
    // A jump overrides any branch decode on the same instruction.
    assign take     = ex_is_jump | cond_taken;

    assign pc_sum   = ex_pc + ex_imm;
    assign jalr_sum = ex_rs1 + ex_imm;
    assign target_w = (ex_is_jump && ex_is_jalr) ? (jalr_sum & ~XLEN'(1)) : pc_sum;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        fcnt_d    = fcnt_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        case (state_q)
            BRU_IDLE: begin
                if (accept) begin
                    if (take) begin
                        target_d = target_w;
                        state_d  = BRU_HOLD;
                    end else begin
                        illegal_d = cond_illegal;
                    end
                end
            end
            BRU_HOLD: begin
                if (redir_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (FLUSH_CYCLES == 0) begin
                        state_d = BRU_IDLE;
                    end else begin
                        state_d = BRU_FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end
            end
            BRU_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = BRU_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: state_d = BRU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= BRU_IDLE;
            target_q  <= '0;
            fcnt_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            fcnt_q    <= fcnt_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign redir_valid  = (state_q == BRU_HOLD);
    assign redir_target = target_q;
    assign flush        = (state_q == BRU_FLUSH);
    assign illegal      = illegal_q;
    assign taken_cnt    = cnt_q;

endmodule
